// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment display driver.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t DIGIT_LAST = 2'd3;
  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [3:0] AN_OFF     = 4'hF;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Active-low anode pattern selecting a single digit.
  function automatic logic [3:0] digit_anode(input digit_idx_t idx);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low segment decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode display scanner: frame-synchronous value update,
// anti-ghosting blank window at each slot start, optional leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic        clk_pi,
  input  logic        reset_n_pi,
  input  logic        num_valid_pi,
  input  logic [15:0] num_pi,
  input  logic        blank_lz_pi,
  input  logic [3:0]  dp_mask_pi,
  output logic [6:0]  seg_po,
  output logic        dp_po,
  output logic [3:0]  an_po,
  output logic        frame_po
);

  localparam int unsigned   PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);

  logic [PW-1:0] presc_q, presc_d;
  digit_idx_t    idx_q, idx_d;
  logic [15:0]   pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic [15:0]   active_q, active_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          frame_q, frame_d;

  logic       slot_tick;
  logic       frame_tick;
  logic [3:0] nibble;
  logic [6:0] seg_dec;
  logic [3:0] lz_blank;
  logic       lit;

  assign slot_tick  = (presc_q == PRESC_LAST);
  assign frame_tick = slot_tick && (idx_q == DIGIT_LAST);

  // Digit k is a leading zero when every nibble from k upward is zero.
  assign lz_blank[0] = 1'b0;
  for (genvar gi = 1; gi < 4; gi++) begin : g_lz
    assign lz_blank[gi] = blank_lz_pi && (active_q[15:4*gi] == '0);
  end

  assign nibble = active_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nibble_i (nibble),
    .seg_o    (seg_dec)
  );

  always_comb begin
    presc_d = slot_tick ? '0 : presc_q + 1'b1;
    idx_d   = slot_tick ? idx_q + 1'b1 : idx_q;
  end

  // Boundary consumes the old pending value before a same-cycle strobe reloads it.
  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    active_d   = active_q;
    if (frame_tick && pend_vld_q) begin
      active_d   = pend_q;
      pend_vld_d = 1'b0;
    end
    if (num_valid_pi) begin
      pend_d     = num_pi;
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    lit     = (presc_q >= BLANK_END) && !lz_blank[idx_q];
    seg_d   = lit ? seg_dec : SEG_OFF;
    dp_d    = lit ? ~dp_mask_pi[idx_q] : 1'b1;
    an_d    = lit ? digit_anode(idx_q) : AN_OFF;
    frame_d = frame_tick;
  end

  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      presc_q    <= '0;
      idx_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      active_q   <= '0;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      an_q       <= AN_OFF;
      frame_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      active_q   <= active_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      frame_q    <= frame_d;
    end
  end

  assign seg_po   = seg_q;
  assign dp_po    = dp_q;
  assign an_po    = an_q;
  assign frame_po = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver: a frame-level model predicts every
// output cycle into a queue, and a negedge monitor pops and compares.
module tb_seg7_scan_driver;

  localparam int unsigned SD    = 8;
  localparam int unsigned BD    = 2;
  localparam int unsigned FRAME = 4 * SD;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame;
  } obs_t;

  localparam obs_t RESET_OBS = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, frame: 1'b0};

  logic        clk_pi = 1'b0;
  logic        reset_n_pi;
  logic        num_valid_pi;
  logic [15:0] num_pi;
  logic        blank_lz_pi;
  logic [3:0]  dp_mask_pi;
  logic [6:0]  seg_po;
  logic        dp_po;
  logic [3:0]  an_po;
  logic        frame_po;

  int          tests = 0;
  int          fails = 0;
  obs_t        exp_q[$];
  int unsigned cyc;
  logic [15:0] committed;
  logic [15:0] latest;

  seg7_scan_driver #(
    .SCAN_DIV  (SD),
    .BLANK_CYC (BD)
  ) dut (
    .clk_pi       (clk_pi),
    .reset_n_pi   (reset_n_pi),
    .num_valid_pi (num_valid_pi),
    .num_pi       (num_pi),
    .blank_lz_pi  (blank_lz_pi),
    .dp_mask_pi   (dp_mask_pi),
    .seg_po       (seg_po),
    .dp_po        (dp_po),
    .an_po        (an_po),
    .frame_po     (frame_po)
  );

  always #5 clk_pi = ~clk_pi;

  function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Output registered at the end of cycle 'c', derived from frame position and the shown value.
  function automatic obs_t model_out(input int unsigned c, input logic [15:0] val,
                                     input logic blz, input logic [3:0] dpm);
    obs_t        r;
    int unsigned pos;
    int unsigned k;
    int unsigned off;
    logic [15:0] upper;
    logic [3:0]  nib;
    logic [3:0]  onehot;
    bit          lit;
    pos    = c % FRAME;
    k      = pos / SD;
    off    = pos % SD;
    upper  = val >> (4 * k);
    nib    = upper[3:0];
    lit    = (off >= BD) && !(blz && k != 0 && upper == 16'h0);
    onehot = 4'b0001 << k;
    r.seg   = lit ? GLYPH[nib] : 7'h7F;
    r.dp    = lit ? ~dpm[k] : 1'b1;
    r.an    = lit ? ~onehot : 4'hF;
    r.frame = (pos == FRAME - 1);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_pi);
    exp_q.push_back(model_out(cyc, committed, blank_lz_pi, dp_mask_pi));
    // Shown value = last strobe sampled strictly before the most recent frame boundary.
    if (cyc % FRAME == FRAME - 1) committed = latest;
    if (num_valid_pi) latest = num_pi;
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [15:0] v);
    num_pi       = v;
    num_valid_pi = 1'b1;
    $display("[TB] strobe num=%04h at frame pos %0d", v, cyc % FRAME);
    tick();
    num_valid_pi = 1'b0;
  endtask

  task automatic wait_pos(input int unsigned p);
    for (int i = 0; i < FRAME && (cyc % FRAME) != p; i++) tick();
    check("wait_pos", 16'(cyc % FRAME), 16'(p));
  endtask

  task automatic pulse_reset();
    reset_n_pi = 1'b0;
    exp_q.delete();
    #1;
    check("rst_seg", {9'h0, seg_po}, 16'h7F);
    check("rst_dp", {15'h0, dp_po}, 16'h1);
    check("rst_an", {12'h0, an_po}, 16'hF);
    check("rst_frame", {15'h0, frame_po}, 16'h0);
    reset_n_pi = 1'b1;
    $display("[TB] reset pulse, scan restarts");
    cyc       = 0;
    committed = 16'h0;
    latest    = 16'h0;
    exp_q.push_back(RESET_OBS);
  endtask

  initial begin
    obs_t e;
    forever begin
      @(negedge clk_pi);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("seg", {9'h0, seg_po}, {9'h0, e.seg});
        check("dp", {15'h0, dp_po}, {15'h0, e.dp});
        check("an", {12'h0, an_po}, {12'h0, e.an});
        check("frame", {15'h0, frame_po}, {15'h0, e.frame});
      end
    end
  end

  initial begin
    logic [15:0] masks [5];
    masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    reset_n_pi   = 1'b0;
    num_valid_pi = 1'b0;
    num_pi       = 16'h0;
    blank_lz_pi  = 1'b0;
    dp_mask_pi   = 4'h0;
    cyc          = 0;
    committed    = 16'h0;
    latest       = 16'h0;
    repeat (3) @(posedge clk_pi);
    #1;
    pulse_reset();

    run(2 * FRAME);                 // idle scan of zeros
    wait_pos(13);
    strobe(16'h12AF);               // mid-frame update
    run(2 * FRAME);
    wait_pos(4);
    strobe(16'h1111);
    run(5);
    strobe(16'h2222);               // last strobe before boundary wins
    run(2 * FRAME);
    wait_pos(FRAME - 1);
    strobe(16'h00F0);               // coincident with boundary tick
    run(2 * FRAME + 10);

    blank_lz_pi = 1'b1;
    wait_pos(3);
    strobe(16'h0005);
    run(2 * FRAME);
    strobe(16'h0000);
    run(2 * FRAME);
    blank_lz_pi = 1'b0;

    for (int i = 0; i < 640; i++) begin
      dp_mask_pi  = 4'($urandom_range(0, 15));
      blank_lz_pi = (i % 97) < 50;
      if ($urandom_range(0, 15) == 0) begin
        strobe(16'($urandom) & masks[$urandom_range(0, 4)]);
      end else begin
        tick();
      end
    end

    blank_lz_pi = 1'b0;
    dp_mask_pi  = 4'h0;
    strobe(16'hBEEF);
    run(2 * FRAME);
    wait_pos(13);
    pulse_reset();                  // mid-slot, no clock edge
    run(2 * FRAME);

    @(negedge clk_pi);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
